mem_stall_controller: RTL and testbench
=======================================

# mem_stall_controller

Multi-cycle sequencer between the control unit's memory signals and a variable-latency data memory. When the decoded instruction asserts MEM_RS or MEM_WS, the block holds the PC, issues one request/acknowledge transaction to data memory and waits for completion. It then releases the PC for exactly one cycle and gates register write-back. Non-memory instructions pass through with zero added latency.

## Interface

Parameters:
- TIMEOUT_CYCLES, default 15: maximum number of WAIT cycles without dmem_ack before the block enters FAULT. Legal range is 1..255.
- DATA_W, default 32: width of address and data buses.

Ports:
- clk  in  1  single system clock; all state changes on the rising edge.
- rst  in  1  asynchronous, active-high reset.
- mem_rs  in  1  memory read request (MEM_RS from decode).
- mem_ws  in  1  memory write request (MEM_WS from decode).
- cntrl_rs  in  1  register write enable from decode (CNTRL_RS).
- mem_addr  in  DATA_W  ALU-computed effective address.
- mem_wdata  in  DATA_W  store data.
- dmem_req  out  1  request to data memory.
- dmem_we  out  1  1 = write, 0 = read; valid while dmem_req=1.
- dmem_addr  out  DATA_W  registered address; valid while dmem_req=1.
- dmem_wdata  out  DATA_W  registered store data.
- dmem_ack  in  1  one-cycle completion pulse from memory.
- dmem_rdata  in  DATA_W  read data; valid in the cycle dmem_ack=1.
- pc_we  out  1  PC write enable.
- rf_we  out  1  register file write enable.
- load_data  out  DATA_W  captured read data for the write-back mux.
- busy  out  1  high in WAIT and DONE.
- fault  out  1  sticky error flag.

## Operation

The state machine has four states: IDLE, WAIT, DONE and FAULT.

- **IDLE**
  - pc_we = ~(mem_rs | mem_ws).
  - rf_we = cntrl_rs & ~(mem_rs | mem_ws).
  - dmem_req = 0.
  - mem_rs XOR mem_ws: register mem_addr, mem_wdata, dmem_we = mem_ws and cntrl_rs; clear the wait counter; go to WAIT.
  - mem_rs & mem_ws (illegal encoding): go to FAULT.
  - dmem_ack in IDLE is ignored.
- **WAIT**
  - dmem_req = 1.
  - dmem_we, dmem_addr and dmem_wdata are held stable.
  - pc_we = 0 and rf_we = 0.
  - Inputs other than dmem_ack and rst are not sampled.
  - dmem_ack = 1: capture dmem_rdata into load_data if the access is a read; go to DONE.
  - Otherwise increment the counter. When the counter reaches TIMEOUT_CYCLES, go to FAULT.
  - dmem_ack in the same cycle as the timeout: the ack wins and the block goes to DONE.
- **DONE**, lasts exactly one cycle
  - dmem_req = 0 and pc_we = 1.
  - rf_we = captured cntrl_rs & ~captured dmem_we. Stores never write the register file.
  - The block always returns to IDLE. It does not re-trigger on the still-present mem_rs/mem_ws, because pc_we advances the PC at this edge.
- **FAULT**
  - fault = 1; dmem_req, pc_we and rf_we = 0.
  - FAULT is left only by rst.
- **Counter:** 8 bits, saturating, cleared on entry to WAIT.
- **load_data:** holds its last captured value until the next read ack; it is not updated on writes.

## Timing

- **Reset values:** state = IDLE, counter = 0, load_data = 0. dmem_addr, dmem_wdata and dmem_we = 0. dmem_req = 0, busy = 0, fault = 0.
  - pc_we and rf_we follow the IDLE combinational equations.
- **Reset timing:** rst takes effect immediately, including mid-transaction. A request in flight is abandoned, and an ack arriving after reset is ignored.
- **Outputs:** dmem_req, dmem_we, dmem_addr, dmem_wdata, busy and fault are registered, decoded from state and registers with no input-to-output path. pc_we and rf_we are combinational from state plus decode inputs.
- **Latency:** decode presents the memory op in cycle N; dmem_req is high from N+1. If the ack arrives in cycle N+1+k (k ≥ 0), DONE occurs in N+2+k. The minimum memory instruction occupancy is 3 cycles (k = 0).
- **Non-memory instructions:** 1 cycle, with pc_we = 1 in the same cycle.
- **Back-to-back memory ops:** the next transaction starts in the cycle after DONE; there is no extra idle cycle.

## Test plan

- **ALU op pass-through:** mem_rs = 0, mem_ws = 0, cntrl_rs = 1 for 3 cycles -> pc_we = 1 and rf_we = 1 each cycle; dmem_req never asserts.
- **Load, ack after 2 WAIT cycles:** mem_rs = 1, cntrl_rs = 1, mem_addr = 0x0000_0040; ack with rdata = 0xDEAD_BEEF in the 3rd WAIT cycle.
  - dmem_req is high for 3 cycles with dmem_addr = 0x40 and dmem_we = 0.
  - Next cycle: pc_we = 1, rf_we = 1, load_data = 0xDEAD_BEEF.
- **Store with ack at k = 0:** mem_ws = 1, mem_wdata = 0x1234_5678.
  - dmem_req for 1 cycle with dmem_we = 1 and dmem_wdata = 0x1234_5678.
  - DONE gives pc_we = 1, rf_we = 0, and load_data unchanged.
- **Timeout:** TIMEOUT_CYCLES = 4 with no ack -> fault = 1 after 4 WAIT cycles; pc_we stays 0; ack sent afterwards has no effect.
  - Repeat with the ack on the 4th cycle -> DONE, fault = 0.
- **Illegal encoding:** mem_rs = mem_ws = 1 in IDLE -> FAULT next cycle, no dmem_req. Asserting rst -> all outputs return to reset values asynchronously.
- **Reset mid-WAIT:** assert rst during the 2nd WAIT cycle -> dmem_req drops immediately and the block is in IDLE. A subsequent load completes normally.

Source files
------------

// File: rtl/mem_stall_controller.sv
// rtl/mem_stall_controller.sv - PC stall sequencer for variable-latency data memory accesses
module mem_stall_controller #(
    parameter int TIMEOUT_CYCLES = 15,
    parameter int DATA_W         = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              mem_rs,
    input  logic              mem_ws,
    input  logic              cntrl_rs,
    input  logic [DATA_W-1:0] mem_addr,
    input  logic [DATA_W-1:0] mem_wdata,
    output logic              dmem_req,
    output logic              dmem_we,
    output logic [DATA_W-1:0] dmem_addr,
    output logic [DATA_W-1:0] dmem_wdata,
    input  logic              dmem_ack,
    input  logic [DATA_W-1:0] dmem_rdata,
    output logic              pc_we,
    output logic              rf_we,
    output logic [DATA_W-1:0] load_data,
    output logic              busy,
    output logic              fault
);

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_WAIT  = 2'd1;
    localparam logic [1:0] S_DONE  = 2'd2;
    localparam logic [1:0] S_FAULT = 2'd3;

    localparam logic [7:0] TIMEOUT_LIMIT = 8'(TIMEOUT_CYCLES);

    logic [1:0] state;
    logic [7:0] wait_cnt;
    logic [7:0] wait_cnt_inc;
    logic       rf_en;
    logic       mem_op;

    assign mem_op       = mem_rs | mem_ws;
    assign wait_cnt_inc = (wait_cnt == 8'hFF) ? wait_cnt : wait_cnt + 8'd1;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= S_IDLE;
            wait_cnt   <= 8'd0;
            rf_en      <= 1'b0;
            dmem_we    <= 1'b0;
            dmem_addr  <= '0;
            dmem_wdata <= '0;
            load_data  <= '0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (mem_rs && mem_ws) begin
                        state <= S_FAULT;
                    end else if (mem_rs ^ mem_ws) begin
                        state      <= S_WAIT;
                        dmem_addr  <= mem_addr;
                        dmem_wdata <= mem_wdata;
                        dmem_we    <= mem_ws;
                        rf_en      <= cntrl_rs;
                        wait_cnt   <= 8'd0;
                    end
                end
                S_WAIT: begin
                    // An ack in the timeout cycle still completes the access.
                    if (dmem_ack) begin
                        if (!dmem_we) begin
                            load_data <= dmem_rdata;
                        end
                        state <= S_DONE;
                    end else begin
                        wait_cnt <= wait_cnt_inc;
                        if (wait_cnt_inc >= TIMEOUT_LIMIT) begin
                            state <= S_FAULT;
                        end
                    end
                end
                S_DONE:  state <= S_IDLE;
                default: state <= S_FAULT;
            endcase
        end
    end

    assign dmem_req = (state == S_WAIT);
    assign busy     = (state == S_WAIT) || (state == S_DONE);
    assign fault    = (state == S_FAULT);

    always_comb begin
        pc_we = 1'b0;
        rf_we = 1'b0;
        case (state)
            S_IDLE: begin
                pc_we = ~mem_op;
                rf_we = cntrl_rs & ~mem_op;
            end
            S_DONE: begin
                pc_we = 1'b1;
                rf_we = rf_en & ~dmem_we;
            end
            default: begin
                pc_we = 1'b0;
                rf_we = 1'b0;
            end
        endcase
    end

endmodule

// File: tb/tb_mem_stall_controller.sv
// tb/tb_mem_stall_controller.sv - directed testbench for mem_stall_controller
module tb_mem_stall_controller;

    logic        clk = 1'b0;
    logic        rst;
    logic        mem_rs, mem_ws, cntrl_rs;
    logic [31:0] mem_addr, mem_wdata;
    logic        dmem_req, dmem_we;
    logic [31:0] dmem_addr, dmem_wdata;
    logic        dmem_ack;
    logic [31:0] dmem_rdata;
    logic        pc_we, rf_we;
    logic [31:0] load_data;
    logic        busy, fault;

    int checks = 0;
    int errors = 0;

    mem_stall_controller #(.TIMEOUT_CYCLES(4), .DATA_W(32)) dut (
        .clk(clk), .rst(rst), .mem_rs(mem_rs), .mem_ws(mem_ws), .cntrl_rs(cntrl_rs),
        .mem_addr(mem_addr), .mem_wdata(mem_wdata), .dmem_req(dmem_req), .dmem_we(dmem_we),
        .dmem_addr(dmem_addr), .dmem_wdata(dmem_wdata), .dmem_ack(dmem_ack),
        .dmem_rdata(dmem_rdata), .pc_we(pc_we), .rf_we(rf_we), .load_data(load_data),
        .busy(busy), .fault(fault)
    );

    always #5 clk = ~clk;

    task automatic clear_inputs();
        mem_rs = 0; mem_ws = 0; cntrl_rs = 0; mem_addr = 0; mem_wdata = 0;
        dmem_ack = 0; dmem_rdata = 0;
    endtask

    task automatic test_reset();
        rst = 1; clear_inputs();
        #2;
        checks++;
        if ({dmem_req, dmem_we, busy, fault, pc_we, rf_we} !== 6'b000010) begin
            errors++;
            $display("FAIL reset_ctl: got req/we/busy/fault/pc/rf=%b expected 000010",
                     {dmem_req, dmem_we, busy, fault, pc_we, rf_we});
        end
        checks++;
        if ({dmem_addr, dmem_wdata, load_data} !== 96'd0) begin
            errors++;
            $display("FAIL reset_data: addr=%h wdata=%h load=%h expected 0", dmem_addr, dmem_wdata, load_data);
        end
        @(negedge clk); rst = 0;
    endtask

    task automatic test_alu_passthrough();
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            mem_rs = 0; mem_ws = 0; cntrl_rs = 1;
            #1;
            checks++;
            if ({pc_we, rf_we, dmem_req} !== 3'b110) begin
                errors++;
                $display("FAIL alu_cycle%0d: pc/rf/req=%b expected 110", i, {pc_we, rf_we, dmem_req});
            end
        end
    endtask

    task automatic test_load();
        @(negedge clk);
        mem_rs = 1; cntrl_rs = 1; mem_addr = 32'h40;
        #1;
        checks++;
        if ({pc_we, rf_we, dmem_req} !== 3'b000) begin
            errors++;
            $display("FAIL load_issue: pc/rf/req=%b expected 000", {pc_we, rf_we, dmem_req});
        end
        for (int w = 1; w <= 3; w++) begin
            @(negedge clk);
            if (w == 3) begin dmem_ack = 1; dmem_rdata = 32'hDEADBEEF; end
            #1;
            checks++;
            if ({dmem_req, dmem_we, pc_we, rf_we, busy} !== 5'b10001 || dmem_addr !== 32'h40) begin
                errors++;
                $display("FAIL load_wait%0d: req/we/pc/rf/busy=%b addr=%h expected 10001 addr=00000040",
                         w, {dmem_req, dmem_we, pc_we, rf_we, busy}, dmem_addr);
            end
        end
        @(negedge clk);
        dmem_ack = 0;
        #1;
        checks++;
        if ({dmem_req, pc_we, rf_we, busy} !== 4'b0111 || load_data !== 32'hDEADBEEF) begin
            errors++;
            $display("FAIL load_done: req/pc/rf/busy=%b load=%h expected 0111 load=deadbeef",
                     {dmem_req, pc_we, rf_we, busy}, load_data);
        end
        @(negedge clk);
        clear_inputs();
        #1;
        checks++;
        if ({dmem_req, busy} !== 2'b00) begin
            errors++;
            $display("FAIL load_no_retrigger: req/busy=%b expected 00", {dmem_req, busy});
        end
    endtask

    task automatic test_store();
        @(negedge clk);
        mem_ws = 1; cntrl_rs = 1; mem_wdata = 32'h12345678; mem_addr = 32'h80;
        @(negedge clk);
        dmem_ack = 1; dmem_rdata = 32'h55555555;
        #1;
        checks++;
        if ({dmem_req, dmem_we} !== 2'b11 || dmem_wdata !== 32'h12345678) begin
            errors++;
            $display("FAIL store_req: req/we=%b wdata=%h expected 11 wdata=12345678", {dmem_req, dmem_we}, dmem_wdata);
        end
        @(negedge clk);
        clear_inputs();
        #1;
        checks++;
        if ({dmem_req, pc_we, rf_we} !== 3'b010 || load_data !== 32'hDEADBEEF) begin
            errors++;
            $display("FAIL store_done: req/pc/rf=%b load=%h expected 010 load=deadbeef",
                     {dmem_req, pc_we, rf_we}, load_data);
        end
    endtask

    task automatic test_timeout();
        @(negedge clk);
        mem_rs = 1; cntrl_rs = 1; mem_addr = 32'h100;
        for (int w = 1; w <= 4; w++) begin
            @(negedge clk);
            #1;
            checks++;
            if ({dmem_req, fault, pc_we} !== 3'b100) begin
                errors++;
                $display("FAIL timeout_wait%0d: req/fault/pc=%b expected 100", w, {dmem_req, fault, pc_we});
            end
        end
        @(negedge clk);
        dmem_ack = 1;
        #1;
        checks++;
        if ({fault, dmem_req, pc_we, busy} !== 4'b1000) begin
            errors++;
            $display("FAIL timeout_fault: fault/req/pc/busy=%b expected 1000", {fault, dmem_req, pc_we, busy});
        end
        @(negedge clk);
        clear_inputs();
        #1;
        checks++;
        if (fault !== 1'b1) begin
            errors++;
            $display("FAIL timeout_sticky: fault=%b expected 1", fault);
        end
        #2; rst = 1; #1;
        checks++;
        if ({fault, dmem_req, busy, pc_we} !== 4'b0001) begin
            errors++;
            $display("FAIL timeout_reset: fault/req/busy/pc=%b expected 0001", {fault, dmem_req, busy, pc_we});
        end
        @(negedge clk); rst = 0;
    endtask

    task automatic test_timeout_ack_wins();
        @(negedge clk);
        mem_rs = 1; cntrl_rs = 1; mem_addr = 32'h104;
        for (int w = 1; w <= 4; w++) begin
            @(negedge clk);
            if (w == 4) begin dmem_ack = 1; dmem_rdata = 32'hA5A5A5A5; end
        end
        @(negedge clk);
        clear_inputs();
        #1;
        checks++;
        if ({fault, pc_we, rf_we, busy} !== 4'b0111 || load_data !== 32'hA5A5A5A5) begin
            errors++;
            $display("FAIL ack_at_timeout: fault/pc/rf/busy=%b load=%h expected 0111 load=a5a5a5a5",
                     {fault, pc_we, rf_we, busy}, load_data);
        end
    endtask

    task automatic test_illegal();
        @(negedge clk);
        mem_rs = 1; mem_ws = 1; cntrl_rs = 1;
        #1;
        checks++;
        if ({pc_we, rf_we, dmem_req} !== 3'b000) begin
            errors++;
            $display("FAIL illegal_idle: pc/rf/req=%b expected 000", {pc_we, rf_we, dmem_req});
        end
        @(negedge clk);
        clear_inputs(); cntrl_rs = 1;
        #1;
        checks++;
        if ({fault, dmem_req, busy} !== 3'b100) begin
            errors++;
            $display("FAIL illegal_fault: fault/req/busy=%b expected 100", {fault, dmem_req, busy});
        end
        #2; rst = 1; #1;
        checks++;
        if ({fault, dmem_req, busy, dmem_we, pc_we, rf_we} !== 6'b000011 || dmem_addr !== 32'd0 || load_data !== 32'd0) begin
            errors++;
            $display("FAIL illegal_reset: fault/req/busy/we/pc/rf=%b addr=%h load=%h expected 000011 0 0",
                     {fault, dmem_req, busy, dmem_we, pc_we, rf_we}, dmem_addr, load_data);
        end
        @(negedge clk); rst = 0; clear_inputs();
    endtask

    task automatic test_reset_mid_wait();
        @(negedge clk);
        mem_rs = 1; cntrl_rs = 1; mem_addr = 32'h200;
        @(negedge clk);
        @(negedge clk);
        #1; rst = 1; #1;
        checks++;
        if ({dmem_req, busy, fault, pc_we} !== 4'b0000) begin
            errors++;
            $display("FAIL midwait_reset: req/busy/fault/pc=%b expected 0000", {dmem_req, busy, fault, pc_we});
        end
        @(negedge clk);
        rst = 0; clear_inputs(); dmem_ack = 1; dmem_rdata = 32'h11111111;
        #1;
        checks++;
        if ({dmem_req, busy, pc_we} !== 3'b001 || dmem_addr !== 32'd0) begin
            errors++;
            $display("FAIL midwait_idle: req/busy/pc=%b addr=%h expected 001 addr=0", {dmem_req, busy, pc_we}, dmem_addr);
        end
        @(negedge clk);
        dmem_ack = 0; mem_rs = 1; cntrl_rs = 1; mem_addr = 32'h300;
        @(negedge clk);
        dmem_ack = 1; dmem_rdata = 32'hCAFEF00D;
        #1;
        checks++;
        if (dmem_req !== 1'b1 || dmem_addr !== 32'h300) begin
            errors++;
            $display("FAIL after_reset_req: req=%b addr=%h expected 1 addr=00000300", dmem_req, dmem_addr);
        end
        @(negedge clk);
        clear_inputs();
        #1;
        checks++;
        if ({pc_we, rf_we} !== 2'b11 || load_data !== 32'hCAFEF00D) begin
            errors++;
            $display("FAIL after_reset_done: pc/rf=%b load=%h expected 11 load=cafef00d", {pc_we, rf_we}, load_data);
        end
    endtask

    initial begin
        test_reset();
        test_alu_passthrough();
        test_load();
        test_store();
        test_timeout();
        test_timeout_ack_wins();
        test_illegal();
        test_reset_mid_wait();
        @(negedge clk);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
